// File: rtl/vec_lsu_sequencer.sv
// Vector load/store element sequencer.
// Issues one memory request per element and writes load data to the VRF.
module vec_lsu_sequencer #(
  parameter int XLEN = 32,
  parameter int VL_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ld_inst,
  input  logic            stride_sel,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [VL_W-1:0] vl,
  input  logic [1:0]      sew,
  input  logic [XLEN-1:0] st_elem_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [1:0]      mem_size,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic [VL_W-1:0] elem_idx,
  output logic            elem_wr_en,
  output logic [XLEN-1:0] elem_data,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic            r_ld;
  logic [1:0]      r_sew;
  logic [VL_W-1:0] r_vl;
  logic [VL_W-1:0] r_idx;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_step;
  logic            r_req_valid;
  logic            r_done;

  logic [XLEN-1:0] w_unit_step;
  logic [XLEN-1:0] w_mask;
  logic [VL_W-1:0] w_idx_nxt;
  logic            w_rsp;

  // Element byte size for the sew seen at launch; 11 behaves as 32b.
  always_comb begin
    w_unit_step = XLEN'(4);
    unique case (sew)
      2'b00:   w_unit_step = XLEN'(1);
      2'b01:   w_unit_step = XLEN'(2);
      default: w_unit_step = XLEN'(4);
    endcase
  end

  // Element data mask for the captured sew.
  always_comb begin
    w_mask = '1;
    unique case (r_sew)
      2'b00:   w_mask = {{(XLEN-8){1'b0}}, 8'hFF};
      2'b01:   w_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      default: w_mask = '1;
    endcase
  end

  assign w_idx_nxt = r_idx + VL_W'(1);
  assign w_rsp     = (r_state == S_WAIT) & mem_rsp_valid;

  // Element loop FSM with registered request/done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ld        <= 1'b0;
      r_sew       <= 2'b00;
      r_vl        <= '0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_step      <= '0;
      r_req_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ld   <= ld_inst;
            r_sew  <= sew;
            r_vl   <= vl;
            r_step <= stride_sel ? w_unit_step : rs2_data;
            r_addr <= rs1_data;
            r_idx  <= '0;
            if (vl != '0) begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            r_addr <= r_addr + r_step;
            r_idx  <= w_idx_nxt;
            if (w_idx_nxt == r_vl) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_addr      = r_addr;
  assign mem_we        = r_req_valid & ~r_ld;
  assign mem_size      = r_sew;
  assign mem_wdata     = r_req_valid ? (st_elem_data & w_mask) : '0;
  assign elem_idx      = r_idx;
  assign elem_wr_en    = w_rsp & r_ld;
  assign elem_data     = elem_wr_en ? (mem_rsp_data & w_mask) : '0;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;

endmodule

// File: doc/vec_lsu_sequencer.md
Name: vec_lsu_sequencer

Overview:
- Multi-cycle sequencer that runs the element loop of one vector load or store issued by the vector decode/control path.
- Captures base, stride, vl and sew at start, then generates one memory request per element: unit-stride or constant-stride.
- Writes returned load data into the vector register file one element at a time and reports completion to the issue logic.
- Indexed (mop=01/11) is out of scope; issue logic must not start it.

Parameters:
- XLEN, 32, width of scalar operands, addresses, memory data.
- VL_W, 9, width of vl and element index (max vl = 2^VL_W - 1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle launch; honoured only when busy=0.
- ld_inst  in  1  1=load, 0=store (captured at start).
- stride_sel  in  1  1=unit stride, 0=strided (captured at start).
- rs1_data  in  XLEN  base address.
- rs2_data  in  XLEN  byte stride, two's-complement (strided only).
- vl  in  VL_W  element count.
- sew  in  2  00=8b, 01=16b, 10=32b; 11 treated as 32b.
- st_elem_data  in  XLEN  store element read from VRF at elem_idx, valid combinationally.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  XLEN  element byte address.
- mem_we  out  1  1=store.
- mem_size  out  2  = captured sew.
- mem_wdata  out  XLEN  st_elem_data, upper bits above sew zeroed.
- mem_rsp_valid  in  1  read data or store ack.
- mem_rsp_data  in  XLEN  load data, element in low sew bits.
- elem_idx  out  VL_W  current element index.
- elem_wr_en  out  1  one-cycle VRF element write strobe (loads only).
- elem_data  out  XLEN  mem_rsp_data masked to sew, upper bits zero.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state) forces state=IDLE and clears all registers. Every output is 0 during and after reset.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - On start, capture ld_inst, stride_sel, sew, vl, and set step = unit ? (1<<sew_bytes_log2) : rs2_data.
  - Set addr_q=rs1_data and elem_idx=0.
  - Go to REQ if vl!=0, else go to DONE.
- REQ:
  - mem_req_valid=1 with mem_addr=addr_q, mem_we=~ld_q.
  - All request fields stay stable while valid && !ready.
  - On ready, go to WAIT_RSP.
- WAIT_RSP:
  - mem_req_valid=0. Wait for mem_rsp_valid; a response is never accepted in the same cycle as the request handshake.
  - On rsp, if load: elem_wr_en=1 that cycle with elem_idx = the current element.
  - On rsp, in either case: addr_q += step (mod 2^XLEN, wrap allowed) and elem_idx += 1.
  - If elem_idx+1 == vl_q go to DONE, else go to REQ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Exactly one request is outstanding at any time.
- Minimum cost is 2 cycles per element.
  - Latency from start to done, with ready=1 and rsp one cycle after accept: 2*vl + 1 cycles.
  - With vl=0: done 1 cycle after start.
- start while busy is ignored; captured state does not change.
- mem_rsp_valid outside WAIT_RSP is ignored.
- Negative stride decrements the address. Stride 0 repeats the same address vl times.
- Captured operands are independent of input changes after start.

Test Plan:
- Unit-stride load, sew=10, vl=4, base=0x1000, ready=1, rsp 1 cycle later -> addrs 0x1000/04/08/0C, elem_wr_en at idx 0..3 with rsp data, done at cycle 9 after start.
- Strided store, sew=00, vl=3, base=0x200, stride=0xFFFFFFFC (-4) -> addrs 0x200/0x1FC/0x1F8, mem_we=1, wdata low byte only, no elem_wr_en, done pulse once.
- Backpressure: ready low 3 cycles on element 1 of a 2-element load -> mem_addr/valid held stable, no second request issued until rsp of element 0, correct final idx.
- vl=0 start -> no mem_req_valid ever, done exactly 1 cycle after start, busy high 1 cycle.
- Address wrap: base=0xFFFFFFFC, unit sew=10, vl=2 -> addrs 0xFFFFFFFC then 0x00000000.
- Async reset asserted in WAIT_RSP mid-load, plus a start pulse while busy -> immediate IDLE, all outputs 0; a new start after reset runs cleanly from idx 0; the start issued while busy is ignored.
